pin_entry_ctrl: RTL and testbench

//  Keypad-side front end of the parking gate: collects BCD keystrokes into a PIN,

---
 rtl/pin_entry_if.sv | 27 ++
 rtl/pin_entry_ctrl.sv | 127 ++++++++++++
 tb/tb_pin_entry_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_entry_if.sv
// Keypad front-end bus: keypad/gate-manager signals in, assembled PIN and status out.
interface pin_entry_if #(
    parameter int DIGITS = 4
);
    logic                  vehicle_present;
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  gate_open;
    logic                  wrong_pin;
    logic [4*DIGITS-1:0]   pin;
    logic                  pin_valid;
    logic [2:0]            digit_cnt;
    logic                  timeout_err;
    logic                  busy;

    // Environment side: drives keystrokes, sensor and gate-manager responses.
    modport master (
        output vehicle_present, key_valid, key_code, gate_open, wrong_pin,
        input  pin, pin_valid, digit_cnt, timeout_err, busy
    );

    // Controller side.
    modport slave (
        input  vehicle_present, key_valid, key_code, gate_open, wrong_pin,
        output pin, pin_valid, digit_cnt, timeout_err, busy
    );
endinterface

// File: rtl/pin_entry_ctrl.sv
// PIN entry controller: assembles BCD keystrokes into a PIN, presents it to the
// gate manager with a one-cycle strobe and holds it until the manager answers.
module pin_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    pin_entry_if.slave    bus
);
    localparam int                PIN_W    = 4 * DIGITS;
    localparam logic [2:0]        CNT_MAX  = 3'(DIGITS);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        COLLECT   = 4'b0010,
        SEND      = 4'b0100,
        WAIT_RESP = 4'b1000
    } state_t;

    state_t            state;
    logic [PIN_W-1:0]  pin_q;
    logic [2:0]        cnt_q;
    logic [TMR_W-1:0]  timer_q;
    logic              pin_valid_q;
    logic              timeout_q;
    logic              busy_q;

    logic key_digit;
    logic key_clear;
    logic key_enter;

    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign key_clear = bus.key_valid && (bus.key_code == 4'hA);
    assign key_enter = bus.key_valid && (bus.key_code == 4'hB);

    assign bus.pin         = pin_q;
    assign bus.pin_valid   = pin_valid_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.timeout_err = timeout_q;
    assign bus.busy        = busy_q;

    // Entry FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pin_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            pin_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pin_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            case (state)
                IDLE: begin
                    pin_q   <= '0;
                    cnt_q   <= '0;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                    if (bus.vehicle_present) state <= COLLECT;
                end
                COLLECT: begin
                    // Departure outranks any keystroke in the same cycle.
                    if (!bus.vehicle_present) begin
                        state   <= IDLE;
                        pin_q   <= '0;
                        cnt_q   <= '0;
                        timer_q <= '0;
                    end else if (key_digit && (cnt_q < CNT_MAX)) begin
                        pin_q   <= (pin_q << 4) | PIN_W'(bus.key_code);
                        cnt_q   <= cnt_q + 3'd1;
                        timer_q <= '0;
                    end else if (key_clear) begin
                        pin_q   <= '0;
                        cnt_q   <= '0;
                        timer_q <= '0;
                    end else if (key_enter && (cnt_q == CNT_MAX)) begin
                        state   <= SEND;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end else if (cnt_q == 3'd0) begin
                        // Nothing typed yet: no inter-key gap to time.
                        timer_q <= '0;
                    end else if (timer_q == TMR_LAST) begin
                        // Ignored keys count as idle time, so they also expire here.
                        timeout_q <= 1'b1;
                        pin_q     <= '0;
                        cnt_q     <= '0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                SEND: begin
                    pin_valid_q <= 1'b1;
                    state       <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    // gate_open beats departure, which beats wrong_pin.
                    if (bus.gate_open || !bus.vehicle_present) begin
                        state  <= IDLE;
                        pin_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.wrong_pin) begin
                        state   <= COLLECT;
                        pin_q   <= '0;
                        cnt_q   <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pin_q   <= '0;
                    cnt_q   <= '0;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: directed vector table, timeout sequence, random run
// against a keystroke-level reference model.
module tb_pin_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int TO_CYC = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pin_entry_if #(.DIGITS(DIGITS)) bus ();

    pin_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT_CYC(TO_CYC), .TMR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: session phase, typed digits as a list, idle cycles since last key.
    localparam int M_OFF = 0, M_ENTRY = 1, M_PRESENT = 2, M_AWAIT = 3;
    int m_mode = M_OFF;
    int m_digits[$];
    int m_idle = 0;
    bit m_valid = 0;
    bit m_to = 0;

    function automatic int m_pin();
        int p = 0;
        foreach (m_digits[i]) p = p * 16 + m_digits[i];
        return p;
    endfunction

    task automatic model_update();
        bit accepted;
        int code;
        code = int'(bus.key_code);
        m_valid = 0;
        m_to = 0;
        if (rst) begin
            m_mode = M_OFF; m_digits.delete(); m_idle = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    m_digits.delete(); m_idle = 0;
                    if (bus.vehicle_present) m_mode = M_ENTRY;
                end
                M_ENTRY: begin
                    if (!bus.vehicle_present) begin
                        m_mode = M_OFF; m_digits.delete(); m_idle = 0;
                    end else begin
                        accepted = 0;
                        if (bus.key_valid) begin
                            if (code <= 9 && m_digits.size() < DIGITS) begin
                                m_digits.push_back(code); accepted = 1;
                            end else if (code == 10) begin
                                m_digits.delete(); accepted = 1;
                            end else if (code == 11 && m_digits.size() == DIGITS) begin
                                m_mode = M_PRESENT; accepted = 1;
                            end
                        end
                        if (accepted) m_idle = 0;
                        else if (m_digits.size() == 0) m_idle = 0;
                        else if (m_idle == TO_CYC - 1) begin
                            m_to = 1; m_digits.delete(); m_idle = 0;
                        end else m_idle++;
                    end
                end
                M_PRESENT: begin
                    m_valid = 1; m_mode = M_AWAIT;
                end
                default: begin
                    if (bus.gate_open || !bus.vehicle_present) begin
                        m_mode = M_OFF; m_digits.delete();
                    end else if (bus.wrong_pin) begin
                        m_mode = M_ENTRY; m_digits.delete(); m_idle = 0;
                    end
                end
            endcase
        end
    endtask

    // One clock: inputs already applied, model follows the edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         pres;
        bit         kv;
        logic [3:0] code;
        bit         gate;
        bit         wrong;
        logic [15:0] pin;
        bit         vld;
        int         cnt;
        bit         to;
        bit         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit r, input bit p, input bit kv, input logic [3:0] c,
                        input bit g, input bit w, input logic [15:0] epin,
                        input bit evld, input int ecnt, input bit eto, input bit ebusy);
        vec_t v;
        v.rst = r; v.pres = p; v.kv = kv; v.code = c; v.gate = g; v.wrong = w;
        v.pin = epin; v.vld = evld; v.cnt = ecnt; v.to = eto; v.busy = ebusy;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit r, input bit p, input bit kv, input logic [3:0] c,
                         input bit g, input bit w);
        rst = r; bus.vehicle_present = p; bus.key_valid = kv; bus.key_code = c;
        bus.gate_open = g; bus.wrong_pin = w;
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] epin, input bit evld,
                                 input int ecnt, input bit eto, input bit ebusy);
        check({tag, " pin"},         32'(bus.pin),         32'(epin));
        check({tag, " pin_valid"},   32'(bus.pin_valid),   32'(evld));
        check({tag, " digit_cnt"},   32'(bus.digit_cnt),   32'(ecnt));
        check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(eto));
        check({tag, " busy"},        32'(bus.busy),        32'(ebusy));
    endtask

    initial begin
        int early;
        drive(1, 0, 0, 4'h0, 0, 0);

        //   rst p kv code  g w  pin      v cnt to busy
        addv(1, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);  // reset
        addv(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);  // IDLE -> COLLECT
        addv(0, 1, 1, 4'h2, 0, 0, 16'h0002, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h4, 0, 0, 16'h0024, 0, 2, 0, 0);
        addv(0, 1, 1, 4'h6, 0, 0, 16'h0246, 0, 3, 0, 0);
        addv(0, 1, 1, 4'h8, 0, 0, 16'h2468, 0, 4, 0, 0);
        addv(0, 1, 1, 4'hB, 0, 0, 16'h2468, 0, 4, 0, 1);  // enter -> SEND
        addv(0, 1, 0, 4'h0, 0, 0, 16'h2468, 1, 4, 0, 1);  // strobe at +2
        addv(0, 1, 0, 4'h0, 0, 0, 16'h2468, 0, 4, 0, 1);  // held in WAIT_RESP
        addv(0, 1, 0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 0);  // gate_open -> IDLE
        addv(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);  // IDLE -> COLLECT
        addv(0, 1, 1, 4'h1, 0, 0, 16'h0001, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h2, 0, 0, 16'h0012, 0, 2, 0, 0);
        addv(0, 1, 1, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 0);  // clear
        addv(0, 1, 1, 4'h3, 0, 0, 16'h0003, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h4, 0, 0, 16'h0034, 0, 2, 0, 0);
        addv(0, 1, 1, 4'h5, 0, 0, 16'h0345, 0, 3, 0, 0);
        addv(0, 1, 1, 4'h6, 0, 0, 16'h3456, 0, 4, 0, 0);
        addv(0, 1, 1, 4'h7, 0, 0, 16'h3456, 0, 4, 0, 0);  // 5th digit ignored
        addv(0, 1, 1, 4'hB, 0, 0, 16'h3456, 0, 4, 0, 1);
        addv(0, 1, 0, 4'h0, 0, 0, 16'h3456, 1, 4, 0, 1);
        addv(0, 1, 0, 4'h0, 0, 1, 16'h0000, 0, 0, 0, 0);  // wrong_pin -> COLLECT
        addv(0, 1, 1, 4'h1, 0, 0, 16'h0001, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h2, 0, 0, 16'h0012, 0, 2, 0, 0);
        addv(0, 1, 1, 4'h3, 0, 0, 16'h0123, 0, 3, 0, 0);
        addv(0, 1, 1, 4'hB, 0, 0, 16'h0123, 0, 3, 0, 0);  // short enter ignored
        addv(0, 1, 1, 4'h4, 0, 0, 16'h1234, 0, 4, 0, 0);
        addv(0, 1, 1, 4'h5, 0, 0, 16'h1234, 0, 4, 0, 0);  // 5th digit ignored
        addv(0, 1, 1, 4'hB, 0, 0, 16'h1234, 0, 4, 0, 1);
        addv(0, 1, 0, 4'h0, 0, 0, 16'h1234, 1, 4, 0, 1);
        addv(0, 1, 0, 4'h0, 1, 1, 16'h0000, 0, 0, 0, 0);  // gate_open wins
        addv(0, 1, 1, 4'h9, 0, 0, 16'h0000, 0, 0, 0, 0);  // key in IDLE ignored
        addv(0, 1, 1, 4'h5, 0, 0, 16'h0005, 0, 1, 0, 0);
        addv(0, 0, 1, 4'h6, 0, 0, 16'h0000, 0, 0, 0, 0);  // departure mid-COLLECT
        addv(0, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);
        addv(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);
        addv(0, 1, 1, 4'h9, 0, 0, 16'h0009, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h8, 0, 0, 16'h0098, 0, 2, 0, 0);
        addv(0, 1, 1, 4'h7, 0, 0, 16'h0987, 0, 3, 0, 0);
        addv(0, 1, 1, 4'h6, 0, 0, 16'h9876, 0, 4, 0, 0);
        addv(0, 1, 1, 4'hB, 0, 0, 16'h9876, 0, 4, 0, 1);
        addv(0, 1, 0, 4'h0, 0, 0, 16'h9876, 1, 4, 0, 1);
        addv(1, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);  // reset in WAIT_RESP
        addv(0, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);
        addv(0, 1, 1, 4'h1, 0, 0, 16'h0001, 0, 1, 0, 0);
        addv(0, 1, 1, 4'h1, 0, 0, 16'h0011, 0, 2, 0, 0);
        addv(0, 1, 1, 4'h1, 0, 0, 16'h0111, 0, 3, 0, 0);
        addv(0, 1, 1, 4'h1, 0, 0, 16'h1111, 0, 4, 0, 0);
        addv(0, 1, 1, 4'hB, 0, 0, 16'h1111, 0, 4, 0, 1);  // SEND
        addv(1, 1, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);  // reset drops strobe
        addv(0, 0, 0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pres, vecs[i].kv, vecs[i].code, vecs[i].gate, vecs[i].wrong);
            step();
            check_outputs($sformatf("vec%0d", i), vecs[i].pin, vecs[i].vld, vecs[i].cnt,
                          vecs[i].to, vecs[i].busy);
        end

        // Inter-key timeout: one digit, then idle until the terminal count.
        drive(0, 1, 0, 4'h0, 0, 0);
        step();
        drive(0, 1, 1, 4'h7, 0, 0);
        step();
        check_outputs("to_key", 16'h0007, 0, 1, 0, 0);
        drive(0, 1, 0, 4'h0, 0, 0);
        early = 0;
        for (int i = 0; i < TO_CYC - 1; i++) begin
            step();
            if (bus.timeout_err !== 1'b0 || bus.digit_cnt !== 3'd1) early++;
        end
        check("to_early", 32'(early), 32'd0);
        step();
        check_outputs("to_fire", 16'h0000, 0, 0, 1, 0);
        step();
        check_outputs("to_after", 16'h0000, 0, 0, 0, 0);
        drive(0, 1, 1, 4'h5, 0, 0);
        step();
        check_outputs("to_resume", 16'h0005, 0, 1, 0, 0);

        // Random traffic against the reference model.
        drive(1, 0, 0, 4'h0, 0, 0);
        step();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] c;
            r = int'($urandom_range(0, 19));
            if (r < 12)      c = 4'(r % 10);
            else if (r < 17) c = 4'hB;
            else if (r == 17) c = 4'hA;
            else             c = 4'hC + 4'($urandom_range(0, 3));
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 29) != 0,
                  $urandom_range(0, 9) < 4,
                  c,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
            step();
            check_outputs($sformatf("rnd%0d", i), 16'(m_pin()), m_valid,
                          m_digits.size(), m_to,
                          (m_mode == M_PRESENT) || (m_mode == M_AWAIT));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
